// File: rtl/gecko_print_uart.sv
`default_nettype none
// ============================================================================
// Module   : gecko_print_uart
// Brief    : Buffers bytes from the gecko print stream in a small FIFO and
//            shifts them out on an 8N1 UART line, back-to-back when queued.
// Revision : 1.0 - initial release
// ============================================================================
module gecko_print_uart #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        print_valid,
    output logic                        print_ready,
    input  logic [7:0]                  print_data,
    output logic                        uart_tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int                 c_aw         = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0]      c_depth      = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [c_aw:0]      c_cnt_one    = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0]    c_ptr_one    = c_aw'(1);
    localparam logic [15:0]        c_bit_reload = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;
    logic [15:0]       r_timer;
    logic [15:0]       w_timer_next;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_tx;
    logic              w_tx_next;
    logic              r_live;
    logic              w_push;
    logic              w_pop;
    logic              w_timer_done;

    // r_live keeps ready low on the first edge after reset release.
    assign print_ready  = r_live && (r_count < c_depth);
    assign w_push       = print_valid && print_ready;
    assign w_timer_done = (r_timer == 16'd0);
    assign tx_busy      = (r_state != IDLE);
    assign uart_tx      = r_tx;
    assign fifo_count   = r_count;

    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_timer_next = c_bit_reload;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_timer_done) begin
                    w_bit_idx_next = 3'd0;
                    w_timer_next   = c_bit_reload;
                    w_state_next   = DATA;
                end else begin
                    w_timer_next = r_timer - 16'd1;
                end
            end
            DATA: begin
                if (w_timer_done) begin
                    w_timer_next = c_bit_reload;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_shift_next   = {1'b0, r_shift[7:1]};
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_timer_next = r_timer - 16'd1;
                end
            end
            STOP: begin
                if (w_timer_done) begin
                    // Chain straight into the next start bit when bytes are waiting.
                    if (r_count != '0) begin
                        w_pop        = 1'b1;
                        w_shift_next = r_mem[r_rd_ptr];
                        w_timer_next = c_bit_reload;
                        w_state_next = START;
                    end else begin
                        w_timer_next = 16'd0;
                        w_state_next = IDLE;
                    end
                end else begin
                    w_timer_next = r_timer - 16'd1;
                end
            end
            default: w_state_next = IDLE;
        endcase

        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_timer   <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= print_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gecko_print_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_gecko_print_uart
// Brief    : Scoreboard bench: accepted bytes are queued, a line decoder
//            rebuilds 8N1 frames from uart_tx and compares in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gecko_print_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       print_valid = 1'b0;
    logic       print_ready;
    logic [7:0] print_data = 8'h00;
    logic       uart_tx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    gecko_print_uart #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .print_valid (print_valid),
        .print_ready (print_ready),
        .print_data  (print_data),
        .uart_tx     (uart_tx),
        .tx_busy     (tx_busy),
        .fifo_count  (fifo_count)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every handshake becomes an expected line byte, in order.
    always @(posedge clk) begin
        if (rst && print_valid && print_ready) begin
            exp_q.push_back(print_data);
        end
    end

    // Line decoder: one sample per clock, 4 samples per bit, 10 bits per frame.
    initial begin : line_decoder
        logic [39:0] s;
        logic [7:0]  b;
        bit          aborted;
        bit          shape_ok;
        forever begin
            @(negedge clk);
            if (rst && !uart_tx) begin
                s       = '0;
                aborted = 1'b0;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk);
                    if (!rst) aborted = 1'b1;
                    s[i] = uart_tx;
                end
                if (!aborted) begin
                    shape_ok = s[36];
                    for (int j = 0; j < 10; j++)
                        for (int k = 1; k < CPB; k++)
                            if (s[CPB*j+k] != s[CPB*j]) shape_ok = 1'b0;
                    for (int j = 0; j < 8; j++) b[j] = s[CPB*(j+1)];
                    check("frame_shape", int'(shape_ok), 1);
                    check("byte_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check("line_byte", int'(b), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic wait_idle();
        int c;
        c = 0;
        while ((tx_busy || fifo_count != 3'd0 || exp_q.size() != 0) && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        check("idle_reached", int'(c < 3000), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] d);
        print_valid = 1'b1;
        print_data  = d;
        @(posedge clk); #1;
        print_valid = 1'b0;
    endtask

    task automatic test_reset_and_release();
        print_valid = 1'b1;
        print_data  = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", int'(uart_tx), 1);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ready", int'(print_ready), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("first_edge_no_accept", int'(fifo_count), 0);
        check("ready_after_release", int'(print_ready), 1);
        print_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_frame_after_release", int'(tx_busy), 0);
    endtask

    task automatic test_single_a5();
        logic [7:0] a5;
        int         exp_tx;
        a5 = 8'hA5;
        push_one(a5);
        check("a5_count_after_push", int'(fifo_count), 1);
        check("a5_no_bypass", int'(tx_busy), 0);
        for (int k = 1; k <= 42; k++) begin
            @(posedge clk); #1;
            if (k <= 4)       exp_tx = 0;
            else if (k <= 36) exp_tx = int'(a5[(k-5)/CPB]);
            else              exp_tx = 1;
            check($sformatf("a5_tx_k%0d", k), int'(uart_tx), exp_tx);
            check($sformatf("a5_busy_k%0d", k), int'(tx_busy), int'(k <= 40));
        end
    endtask

    task automatic test_back_to_back();
        int n, t0, t1;
        bit acc;
        n  = 0;
        t0 = -1;
        t1 = -1;
        print_valid = 1'b1;
        print_data  = 8'h00;
        for (int c = 0; c < 600 && t1 < 0; c++) begin
            acc = print_valid && print_ready;
            @(posedge clk); #1;
            if (acc) begin
                n++;
                if (n < 6) print_data = 8'(n);
                else       print_valid = 1'b0;
            end
            if (c == 4) begin
                check("b2b_full_count", int'(fifo_count), 4);
                check("b2b_full_ready", int'(print_ready), 0);
            end
            if (t0 < 0 && !uart_tx) t0 = c;
            if (t0 >= 0 && !tx_busy) t1 = c;
        end
        print_valid = 1'b0;
        check("b2b_accepted", n, 6);
        check("b2b_line_time", t1 - t0, 240);
    endtask

    task automatic test_push_pop_same_edge();
        for (int k = 0; k <= 41; k++) begin
            print_valid = (k <= 2) || (k == 41);
            print_data  = 8'(8'h10 + k);
            @(posedge clk); #1;
            if (k == 1)  check("pp_idle_pop_push", int'(fifo_count), 1);
            if (k == 2)  check("pp_count_two", int'(fifo_count), 2);
            if (k == 40) check("pp_before_stop_pop", int'(fifo_count), 2);
            if (k == 41) check("pp_same_edge", int'(fifo_count), 2);
        end
        print_valid = 1'b0;
    endtask

    task automatic test_mid_frame_reset();
        int lows;
        push_one(8'h3C);
        push_one(8'h11);
        push_one(8'h22);
        check("rst_mid_queued", int'(fifo_count), 2);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_mid_tx", int'(uart_tx), 1);
        check("rst_mid_count", int'(fifo_count), 0);
        check("rst_mid_busy", int'(tx_busy), 0);
        repeat (2) @(posedge clk);
        #2;
        exp_q.delete();
        rst = 1'b1;
        lows = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (!uart_tx || tx_busy) lows++;
        end
        check("rst_mid_no_frames", lows, 0);
        check("rst_mid_count_after", int'(fifo_count), 0);
    endtask

    task automatic test_pointer_wrap();
        for (int i = 0; i < 9; i++) begin
            push_one(8'($urandom));
            repeat (49) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        int n;
        bit acc;
        n = 0;
        print_valid = 1'b0;
        for (int c = 0; c < 60000 && n < 1000; c++) begin
            if (!print_valid && $urandom_range(1, 0) == 1) begin
                print_valid = 1'b1;
                print_data  = 8'($urandom);
            end
            acc = print_valid && print_ready;
            @(posedge clk); #1;
            if (acc) begin
                n++;
                print_valid = 1'b0;
            end
        end
        print_valid = 1'b0;
        check("rand_accepted", n, 1000);
    endtask

    initial begin
        test_reset_and_release();
        wait_idle();
        test_single_a5();
        wait_idle();
        test_back_to_back();
        wait_idle();
        test_push_pop_same_edge();
        wait_idle();
        test_mid_frame_reset();
        wait_idle();
        test_pointer_wrap();
        wait_idle();
        test_random();
        wait_idle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
